u_rec_ctrl: RTL and testbench
=============================

Name: u_rec_ctrl

Overview:
- Control and buffering stage behind the UART receiver.
- Sequences the receiver's reset on enable and detects completed bytes from the receiver's ready level.
- Buffers bytes in a DEPTH-entry FIFO and presents them to one consumer over a valid/ready handshake.
- Flags overrun and, optionally, an idle-line timeout while unread data sits in the buffer.

Parameters:
DEPTH, 8, FIFO entries; power of 2, minimum 2
TO_CYCLES, 640, sys_clk cycles of stall before timeout pulse; range 2..1023

Ports:
sys_clk  in  1  system clock, all logic on rising edge
sys_rst  in  1  asynchronous, active-high reset
ctrl_enH  in  1  level; 1 = receive path enabled
ctrl_clrH  in  1  one-cycle pulse: flush FIFO, clear overrun and timeout state
rec_dataH  in  8  receiver parallel byte
rec_readyH  in  1  receiver ready level; a rising edge means a new byte is on rec_dataH
rec_rst_l  out  1  active-low reset driven to the receiver
rd_dataH  out  8  FIFO head byte (show-ahead)
rd_validH  out  1  FIFO non-empty
rd_readyH  in  1  consumer accepts rd_dataH when rd_validH=1
fifo_cntH  out  log2(DEPTH)+1  current occupancy
ovr_errH  out  1  sticky overrun flag
timeoutH  out  1  one-cycle idle-timeout pulse

Behaviour:
- Reset values: rec_rst_l=0, rd_validH=0, rd_dataH=0, fifo_cntH=0, ovr_errH=0, timeoutH=0, state=OFF, edge register=1.
- FSM states: OFF, ARM, RUN.
  - OFF: rec_rst_l=0; FIFO pointers and count held at 0; ovr_errH held. ctrl_enH=1 -> ARM.
  - ARM: 4 cycles, counted by a 2-bit counter. rec_rst_l=0 for the first 2 cycles and 1 for the last 2. Then -> RUN.
  - RUN: rec_rst_l=1.
  - ctrl_enH=0 in any state -> OFF on the next cycle. Entering OFF flushes the FIFO; ovr_errH is kept.
- Edge detect:
  - prev register = rec_readyH each cycle, forced to 1 in OFF and ARM.
  - push_req = RUN & rec_readyH & ~prev.
  - rec_dataH is captured in the push_req cycle.
- Latency: push_req in cycle N -> rd_validH=1 and fifo_cntH incremented in cycle N+1.
- Pop: rd_validH & rd_readyH. rd_dataH advances to the next entry in the following cycle.
- rd_dataH is undefined-free: when empty it holds the last-read value, or 0 after reset.
- Boundary conditions:
  - Full, push, no pop: byte dropped, ovr_errH<=1, count unchanged.
  - Full, push and pop together: both performed, count stays DEPTH, no overrun.
  - Empty, push and pop together: cannot occur, because rd_validH=0.
  - Pointers are log2(DEPTH) bits and wrap naturally.
- ctrl_clrH has priority over same-cycle push and pop:
  - pointers and count go to 0, ovr_errH goes to 0, timeout counter goes to 0;
  - the pushed byte is discarded;
  - state is unaffected.
- Reset mid-frame: sys_rst returns everything to the reset values immediately (asynchronous).

Optional Feature:
UREC_TIMEOUT_EN
- Defined:
  - 10-bit stall counter cleared on push, pop, ctrl_clrH, or when not in RUN.
  - Increments while RUN & fifo_cntH!=0.
  - On reaching TO_CYCLES-1, timeoutH=1 for exactly one cycle; the counter then saturates, with no repeat pulse, until the next push, pop or clr.
- Undefined: no counter; timeoutH tied to 0.

Decomposition:
- Package u_rec_pkg holds:
  - state encodings OFF=2'd0, ARM=2'd1, RUN=2'd2;
  - default DEPTH and TO_CYCLES constants;
  - ARM_CYC=4 and ARM_RST_CYC=2.
- Sub-module u_rec_fifo: synchronous show-ahead FIFO, DEPTH x 8, with push/pop/clr, full/empty and count.
  - The overrun decision stays in u_rec_ctrl.

Test Plan:
1. Reset, then ctrl_enH=1 -> rec_rst_l low for exactly 2 cycles, high by cycle 3 of ARM. No push is generated even though the receiver's ready goes 0->1 during ARM. fifo_cntH=0 on entering RUN.
2. In RUN, present rec_dataH=8'hA5 with a rising edge on rec_readyH -> the next cycle gives rd_validH=1, rd_dataH=8'hA5, fifo_cntH=1. Holding rd_readyH=1 -> rd_validH=0 one cycle later.
3. Push 9 bytes 8'h01..8'h09 with rd_readyH=0, DEPTH=8 -> fifo_cntH=8, ovr_errH=1, 8'h09 lost. Drain yields 8'h01..8'h08 in order.
4. FIFO full, with push and pop in the same cycle -> fifo_cntH stays 8, ovr_errH stays 0, and the new byte is read last.
5. ctrl_clrH in the same cycle as a push with 3 entries held -> fifo_cntH=0, rd_validH=0, ovr_errH=0, and the pushed byte is absent.
6. With UREC_TIMEOUT_EN, TO_CYCLES=16: 1 byte buffered, no activity -> a single timeoutH pulse 16 cycles after the push, none afterwards. A pop re-arms the timer. Without the macro, timeoutH is always 0.

Source files
------------

// File: rtl/u_rec_pkg.sv
`default_nettype none
// ============================================================================
// Module      : u_rec_pkg
// Description : Shared types and constants for the UART receive control
//               stage: FSM state encoding, default sizing, arm timing.
// Revision    : 1.0 - initial release
// ============================================================================
package u_rec_pkg;

    // Receive path sequencing states
    typedef enum logic [1:0] {
        OFF = 2'd0,
        ARM = 2'd1,
        RUN = 2'd2
    } recState_t;

    // Default FIFO depth (entries, power of two, >= 2)
    localparam int c_DEF_DEPTH     = 8;
    // Default stall length before the idle-timeout pulse (sys_clk cycles)
    localparam int c_DEF_TO_CYCLES = 640;
    // Total ARM duration and the leading part of it with the receiver held in reset
    localparam int c_ARM_CYC       = 4;
    localparam int c_ARM_RST_CYC   = 2;

endpackage : u_rec_pkg
`default_nettype wire

// File: rtl/u_rec_fifo.sv
`default_nettype none
// ============================================================================
// Module      : u_rec_fifo
// Description : Synchronous show-ahead byte FIFO, DEPTH x 8. The head byte is
//               registered so that it keeps the last value read when the FIFO
//               drains (0 after reset). Clear has priority over push and pop.
// Revision    : 1.0 - initial release
// ============================================================================
module u_rec_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_clr,
    input  logic [7:0]               i_data,
    output logic [7:0]               o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_cnt
);

    localparam int                c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]     c_FULL = (c_AW + 1)'(DEPTH);
    localparam logic [c_AW-1:0]   c_ONE  = c_AW'(1);

    logic [7:0]      r_mem [DEPTH];
    logic [c_AW-1:0] r_wrPtr;
    logic [c_AW-1:0] r_rdPtr;
    logic [c_AW:0]   r_cnt;
    logic [7:0]      r_head;

    logic            w_doPush;
    logic            w_doPop;
    logic [c_AW-1:0] w_nextRdPtr;

    assign o_full      = (r_cnt == c_FULL);
    assign o_empty     = (r_cnt == '0);
    assign w_doPop     = i_pop & ~o_empty;
    // A push into a full FIFO only succeeds when the head leaves in the same cycle
    assign w_doPush    = i_push & (~o_full | w_doPop);
    assign w_nextRdPtr = r_rdPtr + c_ONE;

    assign o_data = r_head;
    assign o_cnt  = r_cnt;

    // Storage array write port
    always_ff @(posedge clk) begin
        if (w_doPush && !i_clr) begin
            r_mem[r_wrPtr] <= i_data;
        end
    end

    // Pointers, occupancy and registered head byte
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_cnt   <= '0;
            r_head  <= 8'h00;
        end else if (i_clr) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_cnt   <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + c_ONE;
            end
            if (w_doPop) begin
                r_rdPtr <= w_nextRdPtr;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
            // Head follows the next stored entry; with only one entry left the
            // incoming byte (if any) becomes the head, otherwise it is held.
            if (w_doPop) begin
                if (r_cnt > (c_AW + 1)'(1)) begin
                    r_head <= r_mem[w_nextRdPtr];
                end else if (w_doPush) begin
                    r_head <= i_data;
                end
            end else if (o_empty && w_doPush) begin
                r_head <= i_data;
            end
        end
    end

endmodule : u_rec_fifo
`default_nettype wire

// File: rtl/u_rec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : u_rec_ctrl
// Description : Control and buffering stage behind the UART receiver.
//               Sequences the receiver reset on enable, turns rising edges of
//               the receiver ready level into FIFO pushes, and hands bytes to
//               one consumer over valid/ready. Flags sticky overrun.
//               Build option UREC_TIMEOUT_EN adds a one-cycle idle-timeout
//               pulse while unread data sits in the buffer; without it
//               timeoutH is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module u_rec_ctrl
    import u_rec_pkg::*;
#(
    parameter int DEPTH     = c_DEF_DEPTH,
    parameter int TO_CYCLES = c_DEF_TO_CYCLES
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst,
    input  logic                     ctrl_enH,
    input  logic                     ctrl_clrH,
    input  logic [7:0]               rec_dataH,
    input  logic                     rec_readyH,
    output logic                     rec_rst_l,
    output logic [7:0]               rd_dataH,
    output logic                     rd_validH,
    input  logic                     rd_readyH,
    output logic [$clog2(DEPTH):0]   fifo_cntH,
    output logic                     ovr_errH,
    output logic                     timeoutH
);

    recState_t  r_state;
    logic [1:0] r_armCnt;
    logic       r_recRstL;
    logic       r_prev;
    logic       r_ovr;

    logic       w_run;
    logic       w_pushReq;
    logic       w_pop;
    logic       w_flush;
    logic       w_overrun;
    logic       w_full;
    logic       w_empty;

    assign w_run     = (r_state == RUN);
    assign w_pushReq = w_run & rec_readyH & ~r_prev;
    assign w_pop     = rd_validH & rd_readyH;
    // Dropping the enable empties the buffer so the FIFO is already clear in OFF
    assign w_flush   = ctrl_clrH | ~ctrl_enH;
    assign w_overrun = w_pushReq & w_full & ~w_pop & ~w_flush;

    assign rec_rst_l = r_recRstL;
    assign rd_validH = ~w_empty;
    assign ovr_errH  = r_ovr;

    // Enable sequencing: OFF -> ARM (receiver reset released half way) -> RUN
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state   <= OFF;
            r_armCnt  <= 2'd0;
            r_recRstL <= 1'b0;
        end else if (!ctrl_enH) begin
            r_state   <= OFF;
            r_armCnt  <= 2'd0;
            r_recRstL <= 1'b0;
        end else begin
            case (r_state)
                OFF: begin
                    r_state   <= ARM;
                    r_armCnt  <= 2'd0;
                    r_recRstL <= 1'b0;
                end
                ARM: begin
                    if (r_armCnt == 2'(c_ARM_CYC - 1)) begin
                        r_state   <= RUN;
                        r_recRstL <= 1'b1;
                    end else begin
                        r_armCnt  <= r_armCnt + 2'd1;
                        r_recRstL <= ((r_armCnt + 2'd1) >= 2'(c_ARM_RST_CYC));
                    end
                end
                RUN: begin
                    r_recRstL <= 1'b1;
                end
                default: begin
                    r_state   <= OFF;
                    r_recRstL <= 1'b0;
                end
            endcase
        end
    end

    // Ready-edge history (held high outside RUN) and sticky overrun flag
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_prev <= 1'b1;
            r_ovr  <= 1'b0;
        end else begin
            r_prev <= w_run ? rec_readyH : 1'b1;
            if (ctrl_clrH) begin
                r_ovr <= 1'b0;
            end else if (w_overrun) begin
                r_ovr <= 1'b1;
            end
        end
    end

    u_rec_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (sys_clk),
        .rst     (sys_rst),
        .i_push  (w_pushReq),
        .i_pop   (w_pop),
        .i_clr   (w_flush),
        .i_data  (rec_dataH),
        .o_data  (rd_dataH),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_cnt   (fifo_cntH)
    );

`ifdef UREC_TIMEOUT_EN
    localparam logic [9:0] c_TO_LAST = 10'(TO_CYCLES - 1);
    localparam logic [9:0] c_TO_PRE  = 10'(TO_CYCLES - 2);

    logic [9:0] r_toCnt;
    logic       r_timeout;

    assign timeoutH = r_timeout;

    // Stall counter: runs while data waits in RUN, saturates after one pulse
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_toCnt   <= 10'd0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            if (ctrl_clrH || w_pushReq || w_pop || !w_run) begin
                r_toCnt <= 10'd0;
            end else if (!w_empty && (r_toCnt != c_TO_LAST)) begin
                r_toCnt <= r_toCnt + 10'd1;
                if (r_toCnt == c_TO_PRE) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end
`else
    logic [9:0] w_unusedToCycles;

    assign w_unusedToCycles = 10'(TO_CYCLES);
    assign timeoutH         = 1'b0;
`endif

endmodule : u_rec_ctrl
`default_nettype wire

// File: tb/tb_u_rec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_u_rec_ctrl
// Description : Self-checking bench for u_rec_ctrl. A reference model tracks
//               enable history, ready edges, occupancy and idle time; bytes
//               accepted by the model are queued and a monitor compares them
//               with what the DUT presents to the consumer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_u_rec_ctrl;

    localparam int DEPTH     = 8;
    localparam int TO_CYCLES = 16;
`ifdef UREC_TIMEOUT_EN
    localparam int EXP_PULSE = 1;
`else
    localparam int EXP_PULSE = 0;
`endif

    logic       sys_clk;
    logic       sys_rst;
    logic       ctrl_enH;
    logic       ctrl_clrH;
    logic [7:0] rec_dataH;
    logic       rec_readyH;
    logic       rec_rst_l;
    logic [7:0] rd_dataH;
    logic       rd_validH;
    logic       rd_readyH;
    logic [3:0] fifo_cntH;
    logic       ovr_errH;
    logic       timeoutH;

    u_rec_ctrl #(
        .DEPTH     (DEPTH),
        .TO_CYCLES (TO_CYCLES)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .ctrl_enH   (ctrl_enH),
        .ctrl_clrH  (ctrl_clrH),
        .rec_dataH  (rec_dataH),
        .rec_readyH (rec_readyH),
        .rec_rst_l  (rec_rst_l),
        .rd_dataH   (rd_dataH),
        .rd_validH  (rd_validH),
        .rd_readyH  (rd_readyH),
        .fifo_cntH  (fifo_cntH),
        .ovr_errH   (ovr_errH),
        .timeoutH   (timeoutH)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Reference model state
    int         m_on;      // consecutive enabled cycles since OFF (saturates at 5)
    int         m_cnt;     // expected occupancy
    int         m_quiet;   // cycles since last push/pop/clear/not-running
    bit         m_prev;    // previous ready level as seen by the edge rule
    bit         m_ovr;
    bit         m_to;
    logic [7:0] exp_q[$];  // scoreboard: bytes the consumer must receive, in order

    int n_cmp = 0;
    int n_err = 0;
    int n_to  = 0;
    bit cur_rdy = 1'b0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_on    = 0;
        m_cnt   = 0;
        m_quiet = 0;
        m_prev  = 1'b1;
        m_ovr   = 1'b0;
        m_to    = 1'b0;
        exp_q.delete();
    endfunction

    // Advance the model across the coming clock edge using the applied inputs
    task automatic model_step();
        bit run;
        bit push;
        bit popHs;
        int cntPre;
        run    = (m_on >= 5);
        push   = run && rec_readyH && !m_prev;
        cntPre = m_cnt;
        popHs  = (cntPre > 0) && rd_readyH;
        if (ctrl_clrH || !ctrl_enH) begin
            m_cnt = 0;
            exp_q.delete();
            if (ctrl_clrH) m_ovr = 1'b0;
        end else begin
            if (popHs) m_cnt--;
            if (push) begin
                if (m_cnt < DEPTH) begin
                    exp_q.push_back(rec_dataH);
                    m_cnt++;
                end else begin
                    m_ovr = 1'b1;
                end
            end
        end
        m_quiet = (ctrl_clrH || push || popHs || !run) ? 0 : m_quiet + 1;
`ifdef UREC_TIMEOUT_EN
        m_to = (m_quiet == TO_CYCLES - 1) && (cntPre > 0);
`else
        m_to = 1'b0;
`endif
        m_prev = run ? rec_readyH : 1'b1;
        m_on   = ctrl_enH ? ((m_on < 5) ? m_on + 1 : 5) : 0;
    endtask

    // Monitor: compare DUT state with the model, consume bytes on handshake
    always @(negedge sys_clk) begin
        chk("rec_rst_l", rec_rst_l, (m_on >= 3));
        chk("fifo_cnt", fifo_cntH, m_cnt);
        chk("rd_valid", rd_validH, (m_cnt > 0));
        chk("ovr_err", ovr_errH, m_ovr);
        chk("timeout", timeoutH, m_to);
        if (timeoutH) n_to++;
        if (rd_validH) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rd_data: got %0d expected no byte at %0t", rd_dataH, $time);
            end else begin
                chk("rd_data", rd_dataH, exp_q[0]);
                if (rd_readyH && !ctrl_clrH) void'(exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input bit en, input bit clr, input bit rdy,
                       input logic [7:0] d, input bit rr);
        @(posedge sys_clk);
        #1;
        ctrl_enH   = en;
        ctrl_clrH  = clr;
        rec_readyH = rdy;
        rec_dataH  = d;
        rd_readyH  = rr;
        cur_rdy    = rdy;
        #6;
        model_step();
    endtask

    task automatic idle(input int n, input bit rr);
        repeat (n) cyc(1'b1, 1'b0, 1'b0, 8'h00, rr);
    endtask

    task automatic push_byte(input logic [7:0] d, input bit rr);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, rr);
        cyc(1'b1, 1'b0, 1'b1, d, rr);
    endtask

    task automatic drive_idle_inputs();
        ctrl_enH   = 1'b0;
        ctrl_clrH  = 1'b0;
        rec_readyH = 1'b0;
        rec_dataH  = 8'h00;
        rd_readyH  = 1'b0;
        cur_rdy    = 1'b0;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        model_reset();
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        drive_idle_inputs();
        #6;
        model_step();
    endtask

    initial begin
        int t0;
        int mode;
        bit rr;
        bit rdy;
        sys_rst = 1'b1;
        drive_idle_inputs();
        model_reset();
        #2;
        chk("reset_rd_data", rd_dataH, 0);
        chk("reset_rec_rst_l", rec_rst_l, 0);
        do_reset();

        // Arming: ready rises during ARM and stays high into RUN -> no push
        cyc(1'b1, 1'b0, 1'b0, 8'h11, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h11, 1'b0);
        repeat (6) cyc(1'b1, 1'b0, 1'b1, 8'h22, 1'b0);
        idle(2, 1'b0);

        // Single byte with the consumer always ready
        push_byte(8'hA5, 1'b1);
        idle(3, 1'b1);

        // Overrun: nine bytes into eight entries, then drain and clear
        for (int i = 1; i <= 9; i++) push_byte(8'(i), 1'b0);
        idle(2, 1'b0);
        idle(10, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i), 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 8'h20, 1'b1);
        idle(12, 1'b1);

        // Clear colliding with a push while three entries are held
        for (int i = 0; i < 3; i++) push_byte(8'h30 + 8'(i), 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 8'hEE, 1'b0);
        idle(3, 1'b0);

        // Idle timeout: one pulse per stall window, re-armed by pop and push
        t0 = n_to;
        push_byte(8'h77, 1'b0);
        idle(30, 1'b0);
        chk("timeout_pulses_1", n_to - t0, EXP_PULSE);
        idle(1, 1'b1);
        t0 = n_to;
        push_byte(8'h78, 1'b0);
        push_byte(8'h79, 1'b0);
        idle(30, 1'b0);
        chk("timeout_pulses_2", n_to - t0, EXP_PULSE);
        idle(1, 1'b1);
        t0 = n_to;
        idle(30, 1'b0);
        chk("timeout_pulses_3", n_to - t0, EXP_PULSE);
        idle(3, 1'b1);

        // Randomized traffic with varying consumer behaviour
        mode = 0;
        for (int i = 0; i < 2500; i++) begin
            if (i % 100 == 0) mode = $urandom_range(0, 3);
            case (mode)
                0:       rr = 1'b0;
                1:       rr = 1'($urandom_range(0, 1));
                2:       rr = 1'b1;
                default: rr = 1'b0;
            endcase
            rdy = cur_rdy;
            if (mode != 3 && $urandom_range(0, 2) == 0) rdy = ~cur_rdy;
            cyc(($urandom_range(0, 399) != 0), ($urandom_range(0, 149) == 0),
                rdy, 8'($urandom), rr);
        end

        // Asynchronous reset with data buffered and overrun set
        idle(8, 1'b0);
        for (int i = 0; i < 10; i++) push_byte(8'h50 + 8'(i), 1'b0);
        @(posedge sys_clk);
        #3;
        sys_rst = 1'b1;
        #1;
        chk("async_rec_rst_l", rec_rst_l, 0);
        chk("async_rd_valid", rd_validH, 0);
        chk("async_rd_data", rd_dataH, 0);
        chk("async_fifo_cnt", fifo_cntH, 0);
        chk("async_ovr_err", ovr_errH, 0);
        chk("async_timeout", timeoutH, 0);
        model_reset();
        do_reset();
        idle(7, 1'b0);
        push_byte(8'h5A, 1'b1);
        idle(4, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_u_rec_ctrl
`default_nettype wire
